// File: rtl/sync_debounce_pkg.sv
// Shared types and constants for the sync_debounce input conditioner.
package sync_debounce_pkg;

  // Debounce FSM state encoding
  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W           = 16;

  // Width of the optional transition statistics counter
  localparam int unsigned STAT_W = 8;

endpackage : sync_debounce_pkg

// File: rtl/sync_debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is a parameter.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // Two-stage resynchronization into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= RESET_VAL;
      r_s2 <= RESET_VAL;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule : sync2

// File: rtl/sync_debounce.sv
// Debounces an asynchronous single-bit input: 2-flop sync, counter FSM,
// registered rise/fall pulses. Optional SYNC_DEBOUNCE_STAT_EN adds a
// saturating 8-bit toggle_cnt output counting rise/fall pulses.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic              q,
  output logic              rise,
  output logic              fall
`ifdef SYNC_DEBOUNCE_STAT_EN
  ,
  output logic [STAT_W-1:0] toggle_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;

  sync2 #(
    .RESET_VAL (RESET_LEVEL)
  ) u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (w_sync)
  );

  // Debounce FSM: q follows the synchronized input only after a full count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_q     <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE: begin
          if (w_sync != r_q) begin
            r_state <= COUNTING;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        COUNTING: begin
          if (w_sync == r_q) begin
            // excursion ended before the count completed
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt >= CNT_LAST) begin
            r_q     <= w_sync;
            r_rise  <= w_sync;
            r_fall  <= ~w_sync;
            r_cnt   <= '0;
            r_state <= STABLE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef SYNC_DEBOUNCE_STAT_EN
  logic [STAT_W-1:0] r_toggle_cnt;

  // Saturating count of emitted rise/fall pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle_cnt <= '0;
    end else if ((r_rise | r_fall) && (r_toggle_cnt != '1)) begin
      r_toggle_cnt <= r_toggle_cnt + STAT_W'(1);
    end
  end

  assign toggle_cnt = r_toggle_cnt;
`endif

endmodule : sync_debounce

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: stimulus pushes expected outputs per
// edge into a queue, a negedge monitor pops and compares.
module tb_sync_debounce;

  localparam int unsigned D  = 4;
  localparam logic        RL = 1'b0;
`ifdef SYNC_DEBOUNCE_STAT_EN
  localparam int N_CLEAN = 300;
`else
  localparam int N_CLEAN = 40;
`endif

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic q, rise, fall;
`ifdef SYNC_DEBOUNCE_STAT_EN
  logic [7:0] toggle_cnt;
`endif

  sync_debounce #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16),
    .RESET_LEVEL     (RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .q     (q),
    .rise  (rise),
    .fall  (fall)
`ifdef SYNC_DEBOUNCE_STAT_EN
    ,
    .toggle_cnt (toggle_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  logic pipe[$];      // input samples still in flight through the synchronizer
  logic m_q;          // model debounced level
  int   m_run;        // consecutive edges the FSM has seen input != level
  int   n_pulses;     // pulses since last reset
  bit   stim_done = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // One clock of stimulus: apply inputs, predict outputs after the next edge
  task automatic step(input logic r, input logic d);
    exp_t e;
    logic v;
    reset = r;
    din   = d;
    e     = '0;
    if (r) begin
      pipe.delete();
      pipe.push_back(RL);
      pipe.push_back(RL);
      m_q      = RL;
      m_run    = 0;
      n_pulses = 0;
    end else begin
      v = pipe.pop_front();
      pipe.push_back(d);
      if (v != m_q) begin
        m_run++;
        if (m_run == int'(D)) begin
          m_q      = v;
          e.rise   = v;
          e.fall   = ~v;
          m_run    = 0;
          n_pulses++;
        end
      end else begin
        m_run = 0;
      end
    end
    e.q = m_q;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, d);
  endtask

  // Stimulus
  initial begin
    logic lvl;
    int   len;
    reset = 1'b1;
    din   = 1'b1;
    m_q   = RL;
    m_run = 0;
    n_pulses = 0;
    pipe.push_back(RL);
    pipe.push_back(RL);

    // reset held 3 cycles with din high, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(1'b1, 10);
    // clean fall
    hold(1'b0, 10);
    // short high pulse is rejected
    hold(1'b1, 2);
    hold(1'b0, 10);
    // bouncing then settling high
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 10);
    // reset while counting, then a full count again
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    hold(1'b1, 10);
    // randomized bursts with occasional reset
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      len = int'($urandom_range(1, 7));
      if ($urandom_range(0, 99) == 0) step(1'b1, lvl);
      lvl = 1'($urandom_range(0, 1));
      hold(lvl, len);
    end
    // clean well-separated transitions
    for (int i = 0; i < N_CLEAN; i++) begin
      lvl = ~lvl;
      hold(lvl, 7);
    end
    hold(lvl, 12);
    stim_done = 1'b1;
  end

  // Monitor: compare each edge's outputs against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (q !== e.q) begin
          n_errors++;
          $display("FAIL q t=%0t actual=%b required=%b", $time, q, e.q);
        end
        n_checks++;
        if (rise !== e.rise) begin
          n_errors++;
          $display("FAIL rise t=%0t actual=%b required=%b", $time, rise, e.rise);
        end
        n_checks++;
        if (fall !== e.fall) begin
          n_errors++;
          $display("FAIL fall t=%0t actual=%b required=%b", $time, fall, e.fall);
        end
        n_checks++;
        if ((rise & fall) !== 1'b0) begin
          n_errors++;
          $display("FAIL pulse_excl t=%0t actual=%b required=0", $time, rise & fall);
        end
      end else if (stim_done) begin
        break;
      end
    end
`ifdef SYNC_DEBOUNCE_STAT_EN
    n_checks++;
    if (toggle_cnt !== 8'((n_pulses > 255) ? 255 : n_pulses)) begin
      n_errors++;
      $display("FAIL toggle_cnt actual=%0d required=%0d", toggle_cnt,
               (n_pulses > 255) ? 255 : n_pulses);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_sync_debounce
